// File: rtl/multi_cycle_controller.sv
// Multi-cycle RV32I-subset control FSM: decodes opcode/funct fields into datapath selects,
// write enables and ALU function, one state per datapath step.
module multi_cycle_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] f3,
    input  logic [6:0] f7,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic       adr_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] imm_src,
    output logic [1:0] result_src,
    output logic [2:0] alu_function,
    output logic       illegal_instr
);

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAddr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExecR,
        StExecI,
        StAluWb,
        StBranch,
        StJal,
        StJalr,
        StJalrLink,
        StLui
    } state_e;

    localparam logic [6:0] OpR     = 7'b0110011;
    localparam logic [6:0] OpI     = 7'b0010011;
    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpBr    = 7'b1100011;
    localparam logic [6:0] OpJal   = 7'b1101111;
    localparam logic [6:0] OpJalr  = 7'b1100111;
    localparam logic [6:0] OpLui   = 7'b0110111;

    localparam logic [2:0] AluAdd  = 3'b000;
    localparam logic [2:0] AluSub  = 3'b001;
    localparam logic [2:0] AluAnd  = 3'b010;
    localparam logic [2:0] AluOr   = 3'b011;
    localparam logic [2:0] AluXor  = 3'b100;
    localparam logic [2:0] AluSlt  = 3'b101;
    localparam logic [2:0] AluSltu = 3'b110;

    state_e state_q, state_d;

    logic pc_write_c, ir_write_c, reg_write_c, mem_write_c;

    // Only f7[5] distinguishes SUB from ADD; the remaining funct7 bits are don't-care here.
    logic unused_f7;
    assign unused_f7 = ^{f7[6], f7[4:0]};

    function automatic logic [2:0] alu_decode(input logic [2:0] fn3, input logic sub);
        logic [2:0] fn;
        case (fn3)
            3'b000:  fn = sub ? AluSub : AluAdd;
            3'b111:  fn = AluAnd;
            3'b110:  fn = AluOr;
            3'b100:  fn = AluXor;
            3'b010:  fn = AluSlt;
            3'b011:  fn = AluSltu;
            default: fn = AluAdd;
        endcase
        return fn;
    endfunction

    always_comb begin
        state_d       = state_q;
        pc_write_c    = 1'b0;
        ir_write_c    = 1'b0;
        reg_write_c   = 1'b0;
        mem_write_c   = 1'b0;
        adr_src       = 1'b0;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        imm_src       = 3'b000;
        result_src    = 2'b00;
        alu_function  = AluAdd;
        illegal_instr = 1'b0;

        unique case (state_q)
            StFetch: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write_c = mem_ready;
                pc_write_c = mem_ready;
                if (mem_ready) state_d = StDecode;
            end
            StDecode: begin
                // Branch target is precomputed here into alu_out.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_src   = 3'b010;
                case (opcode)
                    OpR:             state_d = StExecR;
                    OpI:             state_d = StExecI;
                    OpLoad, OpStore: state_d = StMemAddr;
                    OpBr:            state_d = StBranch;
                    OpJal:           state_d = StJal;
                    OpJalr:          state_d = StJalr;
                    OpLui:           state_d = StLui;
                    default: begin
                        illegal_instr = 1'b1;
                        state_d       = StFetch;
                    end
                endcase
            end
            StMemAddr: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                if (opcode == OpStore) begin
                    imm_src = 3'b001;
                    state_d = StMemWrite;
                end else begin
                    state_d = StMemRead;
                end
            end
            StMemRead: begin
                adr_src = 1'b1;
                if (mem_ready) state_d = StMemWb;
            end
            StMemWb: begin
                result_src  = 2'b01;
                reg_write_c = 1'b1;
                state_d     = StFetch;
            end
            StMemWrite: begin
                adr_src     = 1'b1;
                mem_write_c = 1'b1;
                if (mem_ready) state_d = StFetch;
            end
            StExecR: begin
                alu_src_a    = 2'b10;
                alu_function = alu_decode(f3, f7[5]);
                state_d      = StAluWb;
            end
            StExecI: begin
                alu_src_a    = 2'b10;
                alu_src_b    = 2'b01;
                alu_function = alu_decode(f3, 1'b0);
                state_d      = StAluWb;
            end
            StAluWb: begin
                reg_write_c = 1'b1;
                state_d     = StFetch;
            end
            StBranch: begin
                alu_src_a = 2'b10;
                case (f3)
                    3'b000: begin alu_function = AluSub; pc_write_c = zero;  end
                    3'b001: begin alu_function = AluSub; pc_write_c = !zero; end
                    3'b100: begin alu_function = AluSlt; pc_write_c = !zero; end
                    3'b101: begin alu_function = AluSlt; pc_write_c = zero;  end
                    default: ;
                endcase
                state_d = StFetch;
            end
            StJal: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                pc_write_c = 1'b1;
                state_d    = StAluWb;
            end
            StJalr: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pc_write_c = 1'b1;
                state_d    = StJalrLink;
            end
            StJalrLink: begin
                alu_src_a   = 2'b01;
                alu_src_b   = 2'b10;
                result_src  = 2'b10;
                reg_write_c = 1'b1;
                state_d     = StFetch;
            end
            StLui: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b01;
                imm_src   = 3'b100;
                state_d   = StAluWb;
            end
            default: state_d = StFetch;
        endcase
    end

    // Reset also masks the mem_ready-gated FETCH enables while rst_n is held low.
    assign pc_write  = pc_write_c  & rst_n;
    assign ir_write  = ir_write_c  & rst_n;
    assign reg_write = reg_write_c & rst_n;
    assign mem_write = mem_write_c & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: doc/multi_cycle_controller.md
MULTI_CYCLE_CONTROLLER -- requirements
Module: multi_cycle_controller

Interface
REQ-001 SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-002 SHALL have ports (name direction width meaning):
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  7  instruction[6:0] from the instruction register.
- f3  in  3  instruction[14:12].
- f7  in  7  instruction[31:25].
- zero  in  1  ALU zero flag, combinational for the current cycle.
- mem_ready  in  1  memory accepted or returned the current access.
- pc_write, ir_write, reg_write, mem_write  out  1 each  write enables.
- adr_src  out  1  memory address source: 0 = pc, 1 = alu_out.
- alu_src_a  out  2  ALU A operand: 00 = pc, 01 = old_pc, 10 = rs1, 11 = zero.
- alu_src_b  out  2  ALU B operand: 00 = rs2, 01 = imm, 10 = constant 4.
- imm_src  out  3  immediate type: 000 = I, 001 = S, 010 = B, 011 = J, 100 = U.
- result_src  out  2  result bus: 00 = alu_out reg, 01 = mem data reg, 10 = alu_result.
- alu_function  out  3  ALU operation: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 SLTU.
- illegal_instr  out  1  one-cycle pulse on an unsupported opcode.

Function
REQ-003 SHALL be a Moore FSM, except for the mem_ready-gated and zero-gated enables.
- In every state, any output not listed is 0.
- alu_function defaults to ADD.
REQ-004 FETCH state:
- Drives adr_src=0, alu_src_a=00, alu_src_b=10, ADD, result_src=10.
- ir_write and pc_write are both equal to mem_ready.
- Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
REQ-005 DECODE state drives alu_src_a=01, alu_src_b=01, imm_src=010, ADD; this precomputes the branch target into alu_out.
REQ-006 DECODE next state by opcode:
- 0110011 -> EXEC_R; 0010011 -> EXEC_I.
- 0000011 and 0100011 -> MEM_ADDR.
- 1100011 -> BRANCH; 1101111 -> JAL; 1100111 -> JALR; 0110111 -> LUI.
- Any other opcode -> FETCH with illegal_instr=1 for that one cycle.
REQ-007 MEM_ADDR state:
- Drives alu_src_a=10, alu_src_b=01, ADD.
- imm_src=000 for loads, 001 for stores.
- Goes to MEM_READ (load) or MEM_WRITE (store).
REQ-008 MEM_READ state drives adr_src=1 and holds until mem_ready=1, then goes to MEM_WB.
REQ-009 MEM_WB state drives result_src=01 and reg_write=1, then goes to FETCH.
REQ-010 MEM_WRITE state:
- Drives adr_src=1, result_src=00 and mem_write=1.
- Holds mem_write=1 every cycle until mem_ready=1, then goes to FETCH.
REQ-011 EXEC_R (alu_src_a=10, alu_src_b=00) and EXEC_I (alu_src_a=10, alu_src_b=01, imm_src=000) both go to ALU_WB.
REQ-012 ALU_WB state drives result_src=00 and reg_write=1, then goes to FETCH.
REQ-013 ALU decode in EXEC_R, by f3:
- 000: ADD when f7[5]=0, SUB when f7[5]=1.
- 111 AND; 110 OR; 100 XOR; 010 SLT; 011 SLTU.
- Other f3 values: ADD.
- EXEC_I uses the same table, except f3=000 is always ADD.
REQ-014 BRANCH state:
- Drives alu_src_a=10, alu_src_b=00, result_src=00.
- f3 000/001 use SUB; f3 100/101 use SLT.
- pc_write = zero for beq(000) and bge(101); pc_write = !zero for bne(001) and blt(100); pc_write = 0 for other f3.
- Always goes to FETCH.
REQ-015 JAL state:
- Drives alu_src_a=01, alu_src_b=10, ADD, result_src=00, pc_write=1.
- Goes to ALU_WB, which writes old_pc+4 to rd.
REQ-016 JALR state:
- Drives alu_src_a=10, alu_src_b=01, imm_src=000, ADD, result_src=10, pc_write=1.
- Goes to JALR_LINK.
REQ-017 JALR_LINK state drives alu_src_a=01, alu_src_b=10, ADD, result_src=10, reg_write=1, then goes to FETCH. rd==rs1 is correct because rs1 is consumed in the JALR state.
REQ-018 LUI state drives alu_src_a=11, alu_src_b=01, imm_src=100, ADD, then goes to ALU_WB.
REQ-019 Instruction latency with mem_ready tied to 1:
- R, I, LUI: 4 cycles.
- Load: 5 cycles. Store: 4 cycles.
- Branch: 3 cycles. JAL, JALR: 4 cycles.
- Each wait cycle on mem_ready adds exactly 1 cycle.

Reset
REQ-020 rst_n=0 SHALL immediately force state FETCH.
- While rst_n=0, all write enables are 0, including the mem_ready-gated ones.
- This holds mid-instruction too, including during MEM_WRITE.
REQ-021 After rst_n rises, the first clock edge with mem_ready=1 SHALL complete a fetch.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- add (0110011, f3=000, f7=0), mem_ready=1 -> FETCH, DECODE, EXEC_R(ADD), ALU_WB(reg_write=1), FETCH; 4 cycles.
- sub (f7=0100000) -> alu_function=001 in EXEC_R.
- lw with mem_ready low for 2 cycles in MEM_READ -> 7 cycles total; reg_write only in MEM_WB with result_src=01.
- beq (1100011, f3=000): zero=1 -> pc_write=1 in BRANCH; zero=0 -> pc_write=0; both return to FETCH after 3 cycles.
- jalr -> pc_write=1, result_src=10 in JALR; reg_write=1 in JALR_LINK; alu_src_a=01, alu_src_b=10.
- opcode 1111111 -> illegal_instr=1 for exactly one cycle, back to FETCH, no write enables.
- rst_n dropped in MEM_WRITE -> mem_write=0 asynchronously, state FETCH.
